// File: rtl/gate_vector_sequencer_if.sv
// Stimulus/response bundle between the gate vector sequencer and the gate under test.
interface gate_vector_sequencer_if #(
  parameter int ERR_W = 8
);
  logic             start;
  logic             c;
  logic             a;
  logic             b;
  logic             busy;
  logic             done;
  logic             pass;
  logic             mismatch;
  logic [ERR_W-1:0] err_count;
  logic [1:0]       vec_idx;

  // Sequencer side: drives the gate inputs and the run status.
  modport master (
    input  start, c,
    output a, b, busy, done, pass, mismatch, err_count, vec_idx
  );

  // Environment side: requests runs, returns the gate output, observes status.
  modport slave (
    output start, c,
    input  a, b, busy, done, pass, mismatch, err_count, vec_idx
  );
endinterface

// File: rtl/gate_vector_sequencer.sv
// Drives a 2-input gate through all four input vectors, waits a settle time,
// checks the gate output against AND and reports mismatch count and verdict.
module gate_vector_sequencer #(
  parameter int SETTLE_CYCLES = 2,
  parameter int NUM_PASSES    = 1,
  parameter int ERR_W         = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  gate_vector_sequencer_if.master bus
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] APPLY  = 3'd1;
  localparam logic [2:0] SETTLE = 3'd2;
  localparam logic [2:0] SAMPLE = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  localparam int SW = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam int PW = (NUM_PASSES < 2) ? 1 : $clog2(NUM_PASSES);

  logic [2:0]       state_q,      state_d;
  logic [1:0]       vec_idx_q,    vec_idx_d;
  logic [PW-1:0]    pass_cnt_q,   pass_cnt_d;
  logic [SW-1:0]    settle_cnt_q, settle_cnt_d;
  logic             a_q,          a_d;
  logic             b_q,          b_d;
  logic             busy_q,       busy_d;
  logic             done_q,       done_d;
  logic             pass_q,       pass_d;
  logic             mismatch_q,   mismatch_d;
  logic [ERR_W-1:0] err_q,        err_d;
  logic [ERR_W-1:0] err_next;
  logic [ERR_W-1:0] err_inc;
  logic             exp_c;

  // Next-state and output-register logic for the sweep FSM.
  always_comb begin
    state_d      = state_q;
    vec_idx_d    = vec_idx_q;
    pass_cnt_d   = pass_cnt_q;
    settle_cnt_d = settle_cnt_q;
    a_d          = a_q;
    b_d          = b_q;
    busy_d       = busy_q;
    done_d       = done_q;
    pass_d       = pass_q;
    mismatch_d   = 1'b0;
    err_d        = err_q;
    err_next     = err_q;
    exp_c        = a_q & b_q;
    err_inc      = (err_q == '1) ? err_q : err_q + 1'b1;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          vec_idx_d  = '0;
          pass_cnt_d = '0;
          err_d      = '0;
          done_d     = 1'b0;
          pass_d     = 1'b0;
          busy_d     = 1'b1;
          state_d    = APPLY;
        end
      end
      APPLY: begin
        a_d          = vec_idx_q[1];
        b_d          = vec_idx_q[0];
        settle_cnt_d = SW'(SETTLE_CYCLES);
        state_d      = (SETTLE_CYCLES > 0) ? SETTLE : SAMPLE;
      end
      SETTLE: begin
        settle_cnt_d = settle_cnt_q - 1'b1;
        if (settle_cnt_q == SW'(1)) state_d = SAMPLE;
      end
      SAMPLE: begin
        // Written as "equal -> match, else mismatch" so an unknown c lands on mismatch.
        if (bus.c == exp_c) begin
          mismatch_d = 1'b0;
        end else begin
          mismatch_d = 1'b1;
          err_next   = err_inc;
        end
        err_d = err_next;
        if (vec_idx_q != 2'd3) begin
          vec_idx_d = vec_idx_q + 2'd1;
          state_d   = APPLY;
        end else if (pass_cnt_q < PW'(NUM_PASSES - 1)) begin
          pass_cnt_d = pass_cnt_q + 1'b1;
          vec_idx_d  = '0;
          state_d    = APPLY;
        end else begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          a_d     = 1'b0;
          b_d     = 1'b0;
          pass_d  = (err_next == '0);
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      vec_idx_q    <= '0;
      pass_cnt_q   <= '0;
      settle_cnt_q <= '0;
      a_q          <= 1'b0;
      b_q          <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      mismatch_q   <= 1'b0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      vec_idx_q    <= vec_idx_d;
      pass_cnt_q   <= pass_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      a_q          <= a_d;
      b_q          <= b_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      mismatch_q   <= mismatch_d;
      err_q        <= err_d;
    end
  end

  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.mismatch  = mismatch_q;
  assign bus.err_count = err_q;
  assign bus.vec_idx   = vec_idx_q;

endmodule

// File: tb/tb_gate_vector_sequencer.sv
// Randomized bench for gate_vector_sequencer: three configurations, each
// driven by a truth-table gate model and checked every cycle against a
// schedule computed from the sweep timing rules.
module tb_gate_vector_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] st;
  logic [3:0] tt [3];
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  gate_vector_sequencer_if #(.ERR_W(8)) if0 ();
  gate_vector_sequencer_if #(.ERR_W(8)) if1 ();
  gate_vector_sequencer_if #(.ERR_W(2)) if2 ();

  assign if0.start = st[0];
  assign if1.start = st[1];
  assign if2.start = st[2];
  assign if0.c = tt[0][{if0.a, if0.b}];
  assign if1.c = tt[1][{if1.a, if1.b}];
  assign if2.c = tt[2][{if2.a, if2.b}];

  gate_vector_sequencer #(.SETTLE_CYCLES(2), .NUM_PASSES(1), .ERR_W(8))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.master));
  gate_vector_sequencer #(.SETTLE_CYCLES(0), .NUM_PASSES(2), .ERR_W(8))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.master));
  gate_vector_sequencer #(.SETTLE_CYCLES(2), .NUM_PASSES(2), .ERR_W(2))
    dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.master));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // {a, b, busy, done, pass, mismatch, vec_idx[1:0], err_count[7:0]}
  function automatic logic [15:0] obs(input int k);
    case (k)
      0:       return {if0.a, if0.b, if0.busy, if0.done, if0.pass, if0.mismatch, if0.vec_idx, if0.err_count};
      1:       return {if1.a, if1.b, if1.busy, if1.done, if1.pass, if1.mismatch, if1.vec_idx, if1.err_count};
      default: return {if2.a, if2.b, if2.busy, if2.done, if2.pass, if2.mismatch, if2.vec_idx, 6'd0, if2.err_count};
    endcase
  endfunction

  // Expected outputs t edges after the edge that sampled start.
  // mm[v] = 1 when the gate gives the wrong answer for vector v={a,b}.
  function automatic logic [15:0] model(input int t, input int s, input int p,
                                        input int w, input logic [3:0] mm);
    int v_len = s + 2;
    int len   = 4 * p * v_len;
    int maxe  = (1 << w) - 1;
    int e     = 0;
    int v;
    logic ea, eb, ebusy, edone, epass, emis;
    logic [1:0] evec;
    ebusy = (t < len);
    edone = (t >= len);
    evec  = (t < len) ? 2'((t / v_len) % 4) : 2'd3;
    ea = 1'b0;
    eb = 1'b0;
    if (t >= 1 && t < len) begin
      v  = ((t - 1) / v_len) % 4;
      ea = v[1];
      eb = v[0];
    end
    emis = 1'b0;
    for (int n = 0; n < 4 * p; n++) begin
      if ((n + 1) * v_len <= t && mm[n % 4]) e = (e < maxe) ? e + 1 : e;
      if ((n + 1) * v_len == t && mm[n % 4]) emis = 1'b1;
    end
    epass = edone && (e == 0);
    return {ea, eb, ebusy, edone, epass, emis, evec, 8'(e)};
  endfunction

  task automatic compare_obs(input string tag, input logic [15:0] got, input logic [15:0] exp);
    check({tag, " a"},        32'(got[15]),   32'(exp[15]));
    check({tag, " b"},        32'(got[14]),   32'(exp[14]));
    check({tag, " busy"},     32'(got[13]),   32'(exp[13]));
    check({tag, " done"},     32'(got[12]),   32'(exp[12]));
    check({tag, " pass"},     32'(got[11]),   32'(exp[11]));
    check({tag, " mismatch"}, 32'(got[10]),   32'(exp[10]));
    check({tag, " vec_idx"},  32'(got[9:8]),  32'(exp[9:8]));
    check({tag, " err"},      32'(got[7:0]),  32'(exp[7:0]));
  endtask

  // One run on instance k. hold keeps start high through DONE (back-to-back
  // run), repulse raises start again for edge 5, abort_at >= 0 pulls reset
  // just after that cycle's check.
  task automatic do_run(input int k, input logic [3:0] gate_tt, input bit hold,
                        input bit repulse, input int abort_at);
    int s, p, w, len, runs;
    logic [3:0] mm;
    s    = (k == 1) ? 0 : 2;
    p    = (k == 0) ? 1 : 2;
    w    = (k == 2) ? 2 : 8;
    len  = 4 * p * (s + 2);
    runs = hold ? 2 : 1;
    mm   = gate_tt ^ 4'b1000;
    tt[k] = gate_tt;
    @(negedge clk);
    st[k] = 1'b1;
    for (int r = 0; r < runs; r++) begin
      for (int t = 0; t <= len; t++) begin
        @(posedge clk);
        @(negedge clk);
        compare_obs($sformatf("k%0d r%0d t%0d", k, r, t), obs(k), model(t, s, p, w, mm));
        if (t == 0 && !(hold && r == 0)) st[k] = 1'b0;
        if (repulse && t == 4) st[k] = 1'b1;
        if (repulse && t == 5) st[k] = 1'b0;
        if (t == abort_at) begin
          #2 rst_n = 1'b0;
          #1 compare_obs($sformatf("k%0d async rst", k), obs(k), 16'h0);
          @(posedge clk);
          @(negedge clk);
          compare_obs($sformatf("k%0d in rst", k), obs(k), 16'h0);
          rst_n = 1'b1;
          for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            compare_obs($sformatf("k%0d idle %0d", k, i), obs(k), 16'h0);
          end
          return;
        end
      end
    end
    for (int t = len + 1; t <= len + 2; t++) begin
      @(negedge clk);
      compare_obs($sformatf("k%0d hold t%0d", k, t), obs(k), model(t, s, p, w, mm));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    st    = '0;
    tt[0] = 4'b1000;
    tt[1] = 4'b1000;
    tt[2] = 4'b1000;
    #12;
    for (int k = 0; k < 3; k++) compare_obs($sformatf("k%0d reset", k), obs(k), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    do_run(0, 4'b1000, 1'b0, 1'b0, -1);   // real AND
    do_run(0, 4'b1110, 1'b0, 1'b0, -1);   // OR gate
    do_run(0, 4'b1000, 1'b0, 1'b1, -1);   // start re-pulsed mid-run
    do_run(0, 4'b1111, 1'b1, 1'b0, -1);   // start held through DONE
    do_run(1, 4'b1111, 1'b0, 1'b0, -1);   // stuck-at-1, zero settle, 2 passes
    do_run(2, 4'b1111, 1'b0, 1'b0, -1);   // saturating 2-bit counter
    for (int i = 0; i < 6; i++) do_run(i % 3, 4'($urandom), 1'b0, 1'b0, -1);
    do_run(0, 4'b1110, 1'b0, 1'b0, 9);    // reset mid-SETTLE with err=1

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
